// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that time-shares one CHUNK-bit adder slice
// across a WIDTH-bit word, with a registered carry between slices.
// Optional build macro: SERIAL_ADDER_SUBTRACT_EN adds a 'sub' input that turns
// the operation into a - b - cin (two's-complement, cout=1 means no borrow).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             accept;
    logic             last;

    // One slice of the adder: CHUNK-bit sum with its carry-out in the top bit.
    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    // Two's-complement overflow: like-signed operands giving an unlike-signed result.
    function automatic logic signed_ovf(input logic xm, input logic ym, input logic sm);
        return (xm == ym) && (sm != xm);
    endfunction

    // Operand conditioning: subtraction is addition of ~b with an inverted carry-in.
    always_comb begin
`ifdef SERIAL_ADDER_SUBTRACT_EN
        b_in = sub ? ~b : b;
        c_in = sub ? ~cin : cin;
`else
        b_in = b;
        c_in = cin;
`endif
    end

    assign busy      = (state == RUN);
    assign accept    = (state == IDLE) && start;
    assign last      = (state == RUN) && (cnt == LAST);
    assign chunk_sum = add_chunk(a_sr[CHUNK-1:0], b_sr[CHUNK-1:0], carry);
    // New slice enters at the top; after N slices the word is fully assembled.
    assign res_nxt   = (res_sr >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept a request in IDLE, return after the last slice.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slice counter and visible results; results update only on the final slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cnt <= '0;
            end else if (busy) begin
                cnt <= cnt + CW'(1);
            end
            if (last) begin
                done <= 1'b1;
                sum  <= res_nxt;
                cout <= chunk_sum[CHUNK];
                ovf  <= signed_ovf(a_msb, b_msb, res_nxt[WIDTH-1]);
            end
        end
    end

    // Operand/result shift registers and carry chain; no reset needed, they are
    // always loaded on accept before being used.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr  <= a;
            b_sr  <= b_in;
            carry <= c_in;
            a_msb <= a[WIDTH-1];
            b_msb <= b_in[WIDTH-1];
        end else if (busy) begin
            a_sr   <= a_sr >> CHUNK;
            b_sr   <= b_sr >> CHUNK;
            res_sr <= res_nxt;
            carry  <= chunk_sum[CHUNK];
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (CHUNK = 1, 2, 4, WIDTH = 8) driven
// with directed and random operations, checked against an arithmetic model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    logic       sub;
`endif
    logic       busy_w [3];
    logic       done_w [3];
    logic [7:0] sum_w  [3];
    logic       cout_w [3];
    logic       ovf_w  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
        .sub(sub),
`endif
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));

    serial_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
        .sub(sub),
`endif
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));

    serial_adder #(.WIDTH(8), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
        .sub(sub),
`endif
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic; returns {ovf, cout, sum[7:0]}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic s);
        int ux, uy, sx, sy, r, sr;
        logic [7:0] rs;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        if (s) begin
            r  = ux - uy - int'(c);
            sr = sx - sy - int'(c);
            co = (r >= 0);
        end else begin
            r  = ux + uy + int'(c);
            sr = sx + sy + int'(c);
            co = (r > 255);
        end
        rs = 8'((r + 512) % 256);
        ov = (sr > 127) || (sr < -128);
        return {ov, co, rs};
    endfunction

    task automatic drive(input int sel, input logic st, input logic [7:0] ta,
                         input logic [7:0] tb, input logic tc, input logic ts);
        start_v      = 3'b000;
        start_v[sel] = st;
        a            = ta;
        b            = tb;
        cin          = tc;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        sub          = ts;
`else
        if (ts) $display("note: subtract request ignored in addition-only build");
`endif
    endtask

    // Wait (bounded) for done on instance sel; returns edges waited. Checks that
    // busy stays high and sum stays at its old value while waiting.
    task automatic wait_done(input int sel, input logic [7:0] old_sum, output int k);
        k = 0;
        while (done_w[sel] !== 1'b1 && k < 40) begin
            check($sformatf("busy_c%0d", 1 << sel), busy_w[sel], 1);
            check($sformatf("hold_c%0d", 1 << sel), sum_w[sel], old_sum);
            tick();
            k++;
        end
    endtask

    // One full operation from an idle instance, with latency and result checks.
    task automatic op(input int sel, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic ts, input string tag);
        logic [9:0] exp;
        logic [7:0] old_sum;
        int k;
        exp     = model(ta, tb, tc, ts);
        old_sum = sum_w[sel];
        drive(sel, 1'b1, ta, tb, tc, ts);
        tick();
        drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_done(sel, old_sum, k);
        check({tag, "_lat"},  k, 8 >> sel);
        check({tag, "_sum"},  sum_w[sel], exp[7:0]);
        check({tag, "_cout"}, cout_w[sel], exp[8]);
        check({tag, "_ovf"},  ovf_w[sel], exp[9]);
        check({tag, "_busy"}, busy_w[sel], 0);
        tick();
        check({tag, "_pulse"}, done_w[sel], 0);
    endtask

    initial begin
        int k;
        int seen;
        logic [7:0] ra, rb;
        logic rc, rs;
        int rsel;

        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy%0d", i), busy_w[i], 0);
            check($sformatf("rst_done%0d", i), done_w[i], 0);
            check($sformatf("rst_sum%0d",  i), sum_w[i],  0);
            check($sformatf("rst_cout%0d", i), cout_w[i], 0);
            check($sformatf("rst_ovf%0d",  i), ovf_w[i],  0);
        end
        rst = 1'b0;
        tick();

        // Directed cases.
        op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "t1");
        check("t1_val", sum_w[0], 8'h00);
        op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "t2");
        check("t2_val", {ovf_w[0], cout_w[0], sum_w[0]}, {1'b1, 1'b0, 8'h80});
        op(2, 8'h3C, 8'h4B, 1'b1, 1'b0, "t3");
        check("t3_val", {ovf_w[2], cout_w[2], sum_w[2]}, {1'b1, 1'b0, 8'h88});

        // Start while busy is ignored; start in the done cycle is accepted.
        drive(0, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        drive(0, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        k = 0;
        while (done_w[0] !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("t4_lat1", k + 3, 8);
        check("t4_sum1", sum_w[0], 8'h03);
        drive(0, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("t4_nogap", busy_w[0], 1);
        wait_done(0, 8'h03, k);
        check("t4_lat2", k, 8);
        check("t4_sum2", sum_w[0], 8'h30);
        tick();

        // Reset mid-operation discards the operation.
        drive(0, 1'b1, 8'hAA, 8'h55, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", busy_w[0], 0);
        check("t5_sum",  sum_w[0],  0);
        check("t5_cout", cout_w[0], 0);
        check("t5_ovf",  ovf_w[0],  0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_w[0] === 1'b1) seen++;
            tick();
        end
        check("t5_nodone", seen, 0);
        op(0, 8'h12, 8'h34, 1'b1, 1'b0, "t5_after");

`ifdef SERIAL_ADDER_SUBTRACT_EN
        op(1, 8'h05, 8'h07, 1'b0, 1'b1, "t6_sub");
        check("t6_val", {ovf_w[1], cout_w[1], sum_w[1]}, {1'b0, 1'b0, 8'hFE});
        op(1, 8'h05, 8'h07, 1'b0, 1'b0, "t6_add");
        check("t6_val2", sum_w[1], 8'h0C);
`endif

        // Random operations across all three slice widths.
        for (int i = 0; i < 30; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
`ifdef SERIAL_ADDER_SUBTRACT_EN
            rs   = 1'($urandom);
`else
            rs   = 1'b0;
`endif
            rsel = int'($urandom_range(0, 2));
            op(rsel, ra, rb, rc, rs, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
